// File: rtl/kf76489_pkg.sv
// Shared definitions for the KF76489 bus write sequencer: register codes,
// command layout, sequencer states and byte-encoding helpers.
package kf76489_pkg;

  localparam logic [2:0] TONE1_FREQ = 3'b000;
  localparam logic [2:0] TONE2_FREQ = 3'b010;
  localparam logic [2:0] TONE3_FREQ = 3'b001;
  localparam logic [2:0] NOISE_CTRL = 3'b011;
  localparam logic [2:0] TONE1_ATTN = 3'b100;
  localparam logic [2:0] TONE2_ATTN = 3'b110;
  localparam logic [2:0] TONE3_ATTN = 3'b101;
  localparam logic [2:0] NOISE_ATTN = 3'b111;

  localparam int CMD_W = 13;

  typedef struct packed {
    logic [2:0] reg_code;
    logic [9:0] value;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    L_STB = 3'd1,
    L_GAP = 3'd2,
    D_STB = 3'd3,
    D_GAP = 3'd4
  } seq_state_t;

  // Only the three tone frequency registers carry a second (data) byte.
  function automatic logic is_freq_reg(input logic [2:0] code);
    return (code[2] == 1'b0) && (code != NOISE_CTRL);
  endfunction

  function automatic logic [7:0] latch_byte(input logic [2:0] code, input logic [9:0] value);
    return {value[3:0], code, 1'b1};
  endfunction

  function automatic logic [7:0] data_byte(input logic [9:0] value);
    return {value[9:4], 2'b00};
  endfunction

endpackage

// File: rtl/kf76489_cmd_fifo.sv
// Synchronous command FIFO; pop data is the head entry, valid whenever empty is low.
// Latency: one clock write-to-visible. Push while full and pop while empty are ignored.
module kf76489_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/kf76489_bus_write_sequencer.sv
// Host-side KF76489 write-port driver: buffers register commands and emits
// latch/data bytes on CE_N/WE_N/D_OUT with programmable strobe/gap, stretched by READY.
module kf76489_bus_write_sequencer
  import kf76489_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic [9:0] cmd_value,
  input  logic       READY,
  output logic       CE_N,
  output logic       WE_N,
  output logic [7:0] D_OUT,
  output logic       busy
);

  localparam int STB_LAST = STROBE_CYCLES - 1;
  localparam int GAP_LAST = GAP_CYCLES - 1;
  localparam int CNT_MAX  = (STB_LAST > GAP_LAST) ? STB_LAST : GAP_LAST;
  localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  cmd_t       fifo_dout;
  cmd_t       fifo_din;

  seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t       cur_q, cur_d;
  logic       strb_n_q, strb_n_d;
  logic [7:0] d_out_q, d_out_d;

  assign fifo_din = '{reg_code: cmd_reg, value: cmd_value};

  kf76489_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (cmd_valid),
    .push_dat (fifo_din),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign CE_N      = strb_n_q;
  assign WE_N      = strb_n_q;
  assign D_OUT     = d_out_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    strb_n_d = strb_n_q;
    d_out_d  = d_out_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          d_out_d  = latch_byte(fifo_dout.reg_code, fifo_dout.value);
          strb_n_d = 1'b0;
          cnt_d    = '0;
          state_d  = L_STB;
        end
      end

      L_STB, D_STB: begin
        // Minimum width first; READY only matters once it has elapsed.
        if ((cnt_q >= CNT_W'(STB_LAST)) && READY) begin
          strb_n_d = 1'b1;
          cnt_d    = '0;
          state_d  = (state_q == L_STB) ? L_GAP : D_GAP;
        end else if (cnt_q < CNT_W'(STB_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      L_GAP, D_GAP: begin
        if (cnt_q >= CNT_W'(GAP_LAST)) begin
          cnt_d = '0;
          if ((state_q == L_GAP) && is_freq_reg(cur_q.reg_code)) begin
            d_out_d  = data_byte(cur_q.value);
            strb_n_d = 1'b0;
            state_d  = D_STB;
          end else if (!fifo_empty) begin
            // Back-to-back: launch the next latch byte without visiting IDLE.
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            d_out_d  = latch_byte(fifo_dout.reg_code, fifo_dout.value);
            strb_n_d = 1'b0;
            state_d  = L_STB;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        strb_n_d = 1'b1;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      strb_n_q <= 1'b1;
      d_out_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      strb_n_q <= strb_n_d;
      d_out_q  <= d_out_d;
    end
  end

endmodule

// File: tb/tb_kf76489_bus_write_sequencer.sv
// Directed bench for the KF76489 bus write sequencer with hand-computed bus bytes.
module tb_kf76489_bus_write_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_reg;
  logic [9:0] cmd_value;
  logic       READY;
  logic       CE_N;
  logic       WE_N;
  logic [7:0] D_OUT;
  logic       busy;

  int tests = 0;
  int fails = 0;

  kf76489_bus_write_sequencer #(
    .FIFO_DEPTH    (4),
    .STROBE_CYCLES (1),
    .GAP_CYCLES    (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_reg   (cmd_reg),
    .cmd_value (cmd_value),
    .READY     (READY),
    .CE_N      (CE_N),
    .WE_N      (WE_N),
    .D_OUT     (D_OUT),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Bus capture: bytes at each falling strobe, plus low/high run lengths in clocks.
  logic [7:0] byte_q[$];
  int         low_q[$];
  int         gap_q[$];
  bit         prev_ce = 1'b1;
  int         run = 0;

  always @(negedge clock) begin
    if (reset) begin
      prev_ce = 1'b1;
      run     = 0;
    end else begin
      if (prev_ce && !CE_N) begin
        byte_q.push_back(D_OUT);
        gap_q.push_back(run);
        run = 1;
      end else if (!prev_ce && CE_N) begin
        low_q.push_back(run);
        run = 1;
      end else begin
        run++;
      end
      prev_ce = CE_N;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    byte_q.delete();
    low_q.delete();
    gap_q.delete();
  endtask

  // Starts and ends on a negedge; deasserts cmd_valid after the accepting edge.
  task automatic push(input logic [2:0] r, input logic [9:0] v);
    int n = 0;
    cmd_reg   = r;
    cmd_value = v;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("push_ready", cmd_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  logic [2:0] r4 [5];
  logic [9:0] v4 [5];
  logic [7:0] e4 [6];

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_reg   = 3'b000;
    cmd_value = 10'h000;
    READY     = 1'b1;
    r4 = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001};
    v4 = '{10'h003, 10'h007, 10'h00A, 10'h00F, 10'h3C6};
    e4 = '{8'h39, 8'h7D, 8'hAB, 8'hFF, 8'h63, 8'hF0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ce_n", CE_N, 1'b1);
    check("rst_we_n", WE_N, 1'b1);
    check("rst_d_out", D_OUT, 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // Tone1 frequency: latch 0x51 then data 0xA8, one clock low / one high each.
    clear_capture();
    push(3'b000, 10'h2A5);
    check("lat_idle_ce", CE_N, 1'b1);
    @(negedge clock);
    check("lat_ce_low", CE_N, 1'b0);
    check("lat_we_low", WE_N, 1'b0);
    check("lat_byte", D_OUT, 8'h51);
    @(negedge clock);
    check("lgap_ce", CE_N, 1'b1);
    check("lgap_dout_hold", D_OUT, 8'h51);
    @(negedge clock);
    check("dstb_we", WE_N, 1'b0);
    check("dstb_byte", D_OUT, 8'hA8);
    @(negedge clock);
    check("dgap_ce", CE_N, 1'b1);
    check("dgap_busy", busy, 1'b1);
    @(negedge clock);
    check("t1_busy_drop", busy, 1'b0);
    check("t1_nbytes", byte_q.size(), 2);
    check("t1_byte0", byte_q[0], 8'h51);
    check("t1_byte1", byte_q[1], 8'hA8);
    check("t1_low0", low_q[0], 1);
    check("t1_low1", low_q[1], 1);
    check("t1_gap", gap_q[1], 1);

    // Tone1 attenuation: single byte.
    clear_capture();
    push(3'b100, 10'h005);
    wait_idle("t2_idle");
    repeat (2) @(negedge clock);
    check("t2_nbytes", byte_q.size(), 1);
    check("t2_byte", byte_q[0], 8'h59);

    // Back-to-back pushes with READY low: FIFO fills behind the stalled strobe.
    clear_capture();
    READY = 1'b0;
    for (int i = 0; i < 5; i++) push(r4[i], v4[i]);
    check("t4_full_ready", cmd_ready, 1'b0);
    check("t4_busy", busy, 1'b1);
    check("t4_stall_ce", CE_N, 1'b0);
    check("t4_stall_byte", D_OUT, 8'h39);
    READY = 1'b1;
    wait_idle("t4_idle");
    repeat (2) @(negedge clock);
    check("t4_nbytes", byte_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t4_byte%0d", i), byte_q[i], e4[i]);

    // READY held low through the tone2 latch strobe.
    clear_capture();
    READY = 1'b0;
    push(3'b010, 10'h1B3);
    begin
      int n = 0;
      while (CE_N !== 1'b0 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t5_hold_ce%0d", i), CE_N, 1'b0);
      check($sformatf("t5_hold_dout%0d", i), D_OUT, 8'h35);
      @(negedge clock);
    end
    READY = 1'b1;
    wait_idle("t5_idle");
    repeat (2) @(negedge clock);
    check("t5_nbytes", byte_q.size(), 2);
    check("t5_byte0", byte_q[0], 8'h35);
    check("t5_byte1", byte_q[1], 8'h6C);
    check("t5_low0", low_q[0], 8);
    check("t5_low1", low_q[1], 1);

    // Noise control: upper value bits dropped, no data byte.
    clear_capture();
    push(3'b011, 10'h3FC);
    wait_idle("t6_idle");
    repeat (2) @(negedge clock);
    check("t6_nbytes", byte_q.size(), 1);
    check("t6_byte", byte_q[0], 8'hC7);

    // Asynchronous reset in the middle of a data strobe, with a command queued.
    push(3'b000, 10'h2A5);
    push(3'b100, 10'h003);
    begin
      int n = 0;
      while (!(CE_N === 1'b0 && D_OUT === 8'hA8) && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("t7_in_dstb", D_OUT, 8'hA8);
    #1 reset = 1'b1;
    #1;
    check("t7_async_ce", CE_N, 1'b1);
    check("t7_async_we", WE_N, 1'b1);
    check("t7_async_dout", D_OUT, 8'hFF);
    check("t7_async_busy", busy, 1'b0);
    @(negedge clock);
    clear_capture();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("t7_post_busy", busy, 1'b0);
    check("t7_post_ready", cmd_ready, 1'b1);
    check("t7_post_ce", CE_N, 1'b1);
    check("t7_post_nbytes", byte_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
